cell_mem_ctrl: RTL and testbench

- Sequencing and arbitration controller for one single-port cell position RAM.
- The RAM holds the particle count at address 0 and particles {posz,posy,posx} at addresses 1..N, with a 2-cycle read latency.
- Shares the single port between a read requester (force-evaluation cache fill) and a write requester (motion-update writeback).
- On a granted read, fetches the count, then streams every particle with index and last flags.

---
 rtl/cell_mem_ctrl.sv | 175 +++++++++++++++++
 tb/tb_cell_mem_ctrl.sv | 310 +++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/cell_mem_ctrl.sv
// Cell position RAM controller: arbitrates the single RAM port between a
// burst reader (count word, then every particle) and a single-word writer.
module cell_mem_ctrl #(
    parameter int unsigned DATA_WIDTH   = 96,
    parameter int unsigned PARTICLE_NUM = 220,
    parameter int unsigned ADDR_WIDTH   = 8
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  rd_req,
    output logic                  rd_ack,
    input  logic                  wr_req,
    input  logic [ADDR_WIDTH-1:0] wr_addr,
    input  logic [DATA_WIDTH-1:0] wr_data,
    output logic                  wr_ack,
    output logic [ADDR_WIDTH-1:0] mem_address,
    output logic [DATA_WIDTH-1:0] mem_data,
    output logic                  mem_rden,
    output logic                  mem_wren,
    input  logic [DATA_WIDTH-1:0] mem_q,
    output logic                  out_valid,
    output logic [DATA_WIDTH-1:0] out_data,
    output logic [ADDR_WIDTH-1:0] out_index,
    output logic                  out_last,
    output logic                  rd_done,
    output logic                  busy,
    output logic                  cnt_err,
    output logic [ADDR_WIDTH-1:0] particle_cnt
);

    typedef enum logic [2:0] {
        IDLE,
        RD_CNT,
        CNT_WAIT,
        RD_STREAM,
        DRAIN,
        WR
    } state_t;

    localparam logic [ADDR_WIDTH-1:0] MAX_CNT   = ADDR_WIDTH'(PARTICLE_NUM - 1);
    localparam logic [DATA_WIDTH-1:0] MAX_CNT_W = DATA_WIDTH'(PARTICLE_NUM - 1);

    state_t                  state;
    logic                    phase;          // second cycle of CNT_WAIT / DRAIN
    logic                    last_grant_wr;  // round-robin pointer
    logic                    cnt_over;
    logic [ADDR_WIDTH-1:0]   cnt_clamped;

    // read-return pipeline, one stage behind the RAM's internal register
    logic                    rtn_valid;
    logic [ADDR_WIDTH-1:0]   rtn_index;
    logic                    rtn_last;

    assign out_data = mem_q;

    // The whole word is compared so a count too large for the address field
    // is still flagged rather than silently wrapping.
    always_comb begin
        cnt_over    = (mem_q > MAX_CNT_W);
        cnt_clamped = cnt_over ? MAX_CNT : mem_q[ADDR_WIDTH-1:0];
    end

    // Main sequencer: arbitration, RAM command generation and status outputs
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state         <= IDLE;
            phase         <= 1'b0;
            last_grant_wr <= 1'b1;
            rd_ack        <= 1'b0;
            wr_ack        <= 1'b0;
            mem_address   <= '0;
            mem_data      <= '0;
            mem_rden      <= 1'b0;
            mem_wren      <= 1'b0;
            rd_done       <= 1'b0;
            busy          <= 1'b0;
            cnt_err       <= 1'b0;
            particle_cnt  <= '0;
        end else begin
            rd_ack  <= 1'b0;
            wr_ack  <= 1'b0;
            rd_done <= 1'b0;
            case (state)
                IDLE: begin
                    if (rd_req && (!wr_req || last_grant_wr)) begin
                        state         <= RD_CNT;
                        rd_ack        <= 1'b1;
                        busy          <= 1'b1;
                        mem_rden      <= 1'b1;
                        mem_address   <= '0;
                        last_grant_wr <= 1'b0;
                    end else if (wr_req) begin
                        state         <= WR;
                        wr_ack        <= 1'b1;
                        busy          <= 1'b1;
                        mem_wren      <= 1'b1;
                        mem_address   <= wr_addr;
                        mem_data      <= wr_data;
                        last_grant_wr <= 1'b1;
                    end
                end
                RD_CNT: begin
                    state    <= CNT_WAIT;
                    mem_rden <= 1'b0;
                    phase    <= 1'b0;
                end
                CNT_WAIT: begin
                    if (!phase) begin
                        phase <= 1'b1;
                    end else begin
                        phase        <= 1'b0;
                        particle_cnt <= cnt_clamped;
                        if (cnt_over) cnt_err <= 1'b1;
                        if (cnt_clamped == '0) begin
                            // empty cell: one DRAIN cycle carrying rd_done
                            state   <= DRAIN;
                            rd_done <= 1'b1;
                        end else begin
                            state       <= RD_STREAM;
                            mem_rden    <= 1'b1;
                            mem_address <= ADDR_WIDTH'(1);
                        end
                    end
                end
                RD_STREAM: begin
                    if (mem_address == particle_cnt) begin
                        state       <= DRAIN;
                        mem_rden    <= 1'b0;
                        mem_address <= '0;
                        phase       <= 1'b1;
                    end else begin
                        mem_address <= mem_address + 1'b1;
                    end
                end
                DRAIN: begin
                    if (phase) begin
                        phase   <= 1'b0;
                        rd_done <= 1'b1;
                    end else begin
                        state <= IDLE;
                        busy  <= 1'b0;
                    end
                end
                WR: begin
                    state       <= IDLE;
                    busy        <= 1'b0;
                    mem_wren    <= 1'b0;
                    mem_address <= '0;
                    mem_data    <= '0;
                end
                default: state <= IDLE;
            endcase
        end
    end

    // Align particle tags with the 2-cycle RAM read latency
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            rtn_valid <= 1'b0;
            rtn_index <= '0;
            rtn_last  <= 1'b0;
            out_valid <= 1'b0;
            out_index <= '0;
            out_last  <= 1'b0;
        end else begin
            rtn_valid <= (state == RD_STREAM);
            rtn_index <= (state == RD_STREAM) ? mem_address : '0;
            rtn_last  <= (state == RD_STREAM) && (mem_address == particle_cnt);
            out_valid <= rtn_valid;
            out_index <= rtn_index;
            out_last  <= rtn_last;
        end
    end

endmodule

// File: tb/tb_cell_mem_ctrl.sv
// Self-checking bench for cell_mem_ctrl: RAM model with 2-cycle latency,
// a shadow copy of RAM contents, and expected burst timelines built per cycle.
module tb_cell_mem_ctrl;

    localparam int DW   = 96;
    localparam int PN   = 220;
    localparam int AW   = 8;
    localparam int MAXN = PN - 1;

    logic          clk = 1'b0;
    logic          rst_n = 1'b1;
    logic          rd_req = 1'b0;
    logic          wr_req = 1'b0;
    logic [AW-1:0] wr_addr = '0;
    logic [DW-1:0] wr_data = '0;
    logic          rd_ack, wr_ack, mem_rden, mem_wren;
    logic [AW-1:0] mem_address, out_index, particle_cnt;
    logic [DW-1:0] mem_data, mem_q, out_data;
    logic          out_valid, out_last, rd_done, busy, cnt_err;

    always #5 clk = ~clk;

    cell_mem_ctrl #(
        .DATA_WIDTH  (DW),
        .PARTICLE_NUM(PN),
        .ADDR_WIDTH  (AW)
    ) dut (
        .clk         (clk),
        .rst         (rst_n),
        .rd_req      (rd_req),
        .rd_ack      (rd_ack),
        .wr_req      (wr_req),
        .wr_addr     (wr_addr),
        .wr_data     (wr_data),
        .wr_ack      (wr_ack),
        .mem_address (mem_address),
        .mem_data    (mem_data),
        .mem_rden    (mem_rden),
        .mem_wren    (mem_wren),
        .mem_q       (mem_q),
        .out_valid   (out_valid),
        .out_data    (out_data),
        .out_index   (out_index),
        .out_last    (out_last),
        .rd_done     (rd_done),
        .busy        (busy),
        .cnt_err     (cnt_err),
        .particle_cnt(particle_cnt)
    );

    // RAM model: registered address stage + output register = 2-cycle latency
    logic [DW-1:0] ram [PN];
    logic [DW-1:0] q1;
    logic          bd_we = 1'b0;
    logic [AW-1:0] bd_addr = '0;
    logic [DW-1:0] bd_data = '0;

    always @(posedge clk) begin
        if (mem_rden) q1 <= ram[mem_address];
        mem_q <= q1;
        if (mem_wren) ram[mem_address] <= mem_data;
        if (bd_we) ram[bd_addr] <= bd_data;
    end

    // Reference state kept by the bench
    logic [DW-1:0] model [PN];
    int  checks = 0;
    int  errors = 0;
    bit  last_was_wr = 1'b1;
    bit  err_model = 1'b0;

    typedef struct {
        logic [DW-1:0] count;
        logic [AW-1:0] exp_cnt;
        logic          exp_err;
    } vec_t;
    vec_t vecs [7];

    task automatic check(input string name, input logic [127:0] act, input logic [127:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    function automatic logic [127:0] outs_nodata();
        return 128'({rd_ack, wr_ack, mem_address, mem_rden, mem_wren, out_valid,
                     out_index, out_last, rd_done, busy, cnt_err, particle_cnt});
    endfunction

    function automatic logic [DW-1:0] rand_word();
        return {$urandom, $urandom, $urandom};
    endfunction

    task automatic bd_write(input int a, input logic [DW-1:0] d);
        bd_addr = AW'(a);
        bd_data = d;
        bd_we   = 1'b1;
        @(negedge clk);
        bd_we   = 1'b0;
        model[a] = d;
    endtask

    task automatic start_write(input int a, input logic [DW-1:0] d);
        wr_addr = AW'(a);
        wr_data = d;
        wr_req  = 1'b1;
    endtask

    // Waits for wr_ack and checks the write cycle; optionally checks the idle gap.
    task automatic finish_write(input int a, input logic [DW-1:0] d, input int exp_lat, input bit keep);
        int t;
        t = 0;
        @(negedge clk);
        t = 1;
        while (!wr_ack && t < 40) begin
            @(negedge clk);
            t++;
        end
        if (!wr_ack) begin
            check("wr_ack_timeout", 128'(0), 128'(1));
            wr_req = 1'b0;
            return;
        end
        last_was_wr = 1'b1;
        model[a] = d;
        check("wr_latency", 128'(t), 128'(exp_lat));
        check("wr_cycle", 128'({rd_ack, mem_rden, mem_wren, busy, out_valid, rd_done, mem_address, mem_data}),
              128'({1'b0, 1'b0, 1'b1, 1'b1, 1'b0, 1'b0, AW'(a), d}));
        if (!keep) begin
            wr_req = 1'b0;
            @(negedge clk);
            check("wr_after", 128'({wr_ack, mem_wren, mem_rden, busy, mem_address, mem_data}), 128'(0));
        end
    endtask

    // Full read burst, checked cycle by cycle against the timeline derived
    // from the count word currently held in the shadow model.
    task automatic run_read(input int exp_lat);
        logic [DW-1:0]  c;
        logic [127:0]   act, exp;
        int n, endk, t;
        bit e_rden, e_valid, e_last, e_done, e_busy;
        int e_addr, e_idx;
        c = model[0];
        if (c > DW'(MAXN)) begin
            n = MAXN;
            err_model = 1'b1;
        end else begin
            n = int'(c[AW-1:0]);
        end
        endk = (n == 0) ? 3 : 4 + n;
        rd_req = 1'b1;
        @(negedge clk);
        t = 1;
        while (!rd_ack && t < 40) begin
            @(negedge clk);
            t++;
        end
        rd_req = 1'b0;
        if (!rd_ack) begin
            check("rd_ack_timeout", 128'(0), 128'(1));
            return;
        end
        last_was_wr = 1'b0;
        if (exp_lat > 0) check("rd_latency", 128'(t), 128'(exp_lat));
        for (int k = 0; k <= endk + 1; k++) begin
            if (k > 0) @(negedge clk);
            e_rden  = (k == 0) || (k >= 3 && k <= 2 + n);
            e_addr  = (k >= 3 && k <= 2 + n) ? k - 2 : 0;
            e_valid = (n > 0) && (k >= 5) && (k <= 4 + n);
            e_idx   = e_valid ? k - 4 : 0;
            e_last  = (n > 0) && (k == 4 + n);
            e_done  = (k == endk);
            e_busy  = (k <= endk);
            act = 128'({rd_ack, wr_ack, mem_rden, mem_wren, out_valid, out_last, rd_done, busy,
                        mem_address, out_index, mem_data});
            exp = 128'({k == 0, 1'b0, e_rden, 1'b0, e_valid, e_last, e_done, e_busy,
                        AW'(e_addr), AW'(e_idx), DW'(0)});
            check($sformatf("rd_ctl n=%0d k=%0d", n, k), act, exp);
            if (e_valid) check($sformatf("rd_data idx=%0d", e_idx), 128'(out_data), 128'(model[e_idx]));
        end
        check("particle_cnt", 128'(particle_cnt), 128'(n));
        check("cnt_err", 128'(cnt_err), 128'(err_model));
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [DW-1:0] d, d2;
        int a, op, t;

        vecs[0] = '{count: 96'd3,   exp_cnt: 8'd3,   exp_err: 1'b0};
        vecs[1] = '{count: 96'd0,   exp_cnt: 8'd0,   exp_err: 1'b0};
        vecs[2] = '{count: 96'd1,   exp_cnt: 8'd1,   exp_err: 1'b0};
        vecs[3] = '{count: 96'd219, exp_cnt: 8'd219, exp_err: 1'b0};
        vecs[4] = '{count: 96'd300, exp_cnt: 8'd219, exp_err: 1'b1};
        vecs[5] = '{count: 96'd220, exp_cnt: 8'd219, exp_err: 1'b1};
        vecs[6] = '{count: 96'd6,   exp_cnt: 8'd6,   exp_err: 1'b1};

        // asynchronous reset, outputs all low
        #2 rst_n = 1'b0;
        #1;
        check("reset_outs", outs_nodata(), 128'(0));
        check("reset_mem_data", 128'(mem_data), 128'(0));

        // fill RAM while held in reset
        @(negedge clk);
        bd_write(0, DW'(3));
        for (int i = 1; i < PN; i++) bd_write(i, rand_word());

        // both requests from reset: read first, then write, then read again
        d  = rand_word();
        d2 = rand_word();
        start_write(10, d);
        rst_n = 1'b1;
        last_was_wr = 1'b1;
        run_read(1);
        finish_write(10, d, 1, 1'b1);
        wr_addr = AW'(20);
        wr_data = d2;
        run_read(2);
        finish_write(20, d2, 1, 1'b0);

        // table of count values incl. zero, full and overflow
        for (int i = 0; i < 7; i++) begin
            bd_write(0, vecs[i].count);
            run_read(1);
            check($sformatf("tbl%0d_cnt", i), 128'(particle_cnt), 128'(vecs[i].exp_cnt));
            check($sformatf("tbl%0d_err", i), 128'(cnt_err), 128'(vecs[i].exp_err));
        end

        // back-to-back writes, first one updates the count word
        d = rand_word();
        start_write(0, DW'(5));
        finish_write(0, DW'(5), 1, 1'b1);
        wr_addr = AW'(7);
        wr_data = d;
        finish_write(7, d, 2, 1'b0);
        check("cnt_after_writes", 128'(particle_cnt), 128'(6));
        run_read(1);

        // randomized mix of operations against the shadow model
        for (int it = 0; it < 40; it++) begin
            op = int'($urandom_range(0, 3));
            case (op)
                0: begin
                    a = int'($urandom_range(1, MAXN));
                    d = rand_word();
                    start_write(a, d);
                    finish_write(a, d, 1, 1'b0);
                end
                1: begin
                    d = DW'($urandom_range(0, 300));
                    start_write(0, d);
                    finish_write(0, d, 1, 1'b0);
                end
                2: run_read(1);
                default: begin
                    a = int'($urandom_range(1, MAXN));
                    d = rand_word();
                    start_write(a, d);
                    if (last_was_wr) begin
                        run_read(1);
                        finish_write(a, d, 1, 1'b0);
                    end else begin
                        rd_req = 1'b1;
                        finish_write(a, d, 1, 1'b0);
                        run_read(1);
                    end
                end
            endcase
        end

        // reset in the middle of an N=10 burst
        bd_write(0, DW'(10));
        rd_req = 1'b1;
        @(negedge clk);
        t = 1;
        while (!rd_ack && t < 40) begin
            @(negedge clk);
            t++;
        end
        rd_req = 1'b0;
        check("mid_rst_ack", 128'(rd_ack), 128'(1));
        repeat (6) @(negedge clk);
        rst_n = 1'b0;
        #1;
        check("mid_rst_outs", outs_nodata(), 128'(0));
        check("mid_rst_mem_data", 128'(mem_data), 128'(0));
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        last_was_wr = 1'b1;
        err_model = 1'b0;
        for (int k = 0; k < 8; k++) begin
            @(negedge clk);
            check($sformatf("post_rst k=%0d", k), outs_nodata(), 128'(0));
        end
        run_read(1);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
